// File: rtl/ibuf_burst_writer_pkg.sv
// Shared types and sizing helpers for the input-buffer writer and data router.
// Write-port field widths are fixed so both sides agree on the bus layout.
package ibuf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int WBANK_W = 8;
   localparam int WROW_W  = 8;
   localparam int WCOL_W  = 28;

   // Rows held per bank: two stride windows so one can fill while the other drains.
   function automatic int bufh_of(input int stride);
      return 2 * stride;
   endfunction

   // Row address length: bits needed to index BUFH rows (at least one).
   function automatic int ral(input int bufh);
      return (bufh > 1) ? $clog2(bufh) : 1;
   endfunction

   // Line-memory depth in words for one bank.
   function automatic int lm(input int bufw, input int bufh);
      return bufw * bufh;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ibuf_burst_writer_if.sv
// Command, stream and buffer-write signals of the burst writer.
// Handshakes: a transfer happens on the rising edge where valid && ready; valid never waits on ready.
interface ibuf_burst_writer_if #(
   parameter int DW   = 32,
   parameter int CNTW = 16
);
   import ibuf_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        cmd_bank;
   logic [7:0]        cmd_row;
   logic [CNTW-1:0]   cmd_nburst;

   logic              s_valid;
   logic              s_ready;
   logic [DW-1:0]     s_data;
   logic              s_last;

   logic              wvalid;
   logic [DW-1:0]     wdata;
   logic [WBANK_W-1:0] wbank;
   logic [WROW_W-1:0] wrow;
   logic [WCOL_W-1:0] wcol;
   logic              row_done;
   logic              done;
   logic              err_last;
   state_t            dbg_state;

   modport master (
      output cmd_valid, cmd_bank, cmd_row, cmd_nburst, s_valid, s_data, s_last,
      input  cmd_ready, s_ready, wvalid, wdata, wbank, wrow, wcol,
             row_done, done, err_last, dbg_state
   );

   modport slave (
      input  cmd_valid, cmd_bank, cmd_row, cmd_nburst, s_valid, s_data, s_last,
      output cmd_ready, s_ready, wvalid, wdata, wbank, wrow, wcol,
             row_done, done, err_last, dbg_state
   );

endinterface

// File: rtl/ibuf_burst_writer_addr_gen.sv
// ibuf_addr_gen: wrap-around column/row/bank counter for buffer writes.
// Column runs 0..BUFW-1; each row wrap advances row, then bank, modulo BUFH and POY.
module ibuf_addr_gen
   import ibuf_pkg::*;
#(
   parameter int POY  = 3,
   parameter int BUFH = 2,
   parameter int BUFW = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [7:0]              load_bank,
   input  logic [7:0]              load_row,
   input  logic                    advance,
   output logic [idx_w(POY)-1:0]   bank,
   output logic [ral(BUFH)-1:0]    row,
   output logic [idx_w(BUFW)-1:0]  col,
   output logic                    last_col
);
   localparam int BW = idx_w(POY);
   localparam int RW = ral(BUFH);
   localparam int CW = idx_w(BUFW);

   logic [BW-1:0] bank_q, bank_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;

   always_comb begin
      last_col = (col_q == CW'(BUFW - 1));
      bank_d   = bank_q;
      row_d    = row_q;
      col_d    = col_q;
      if (load) begin
         bank_d = BW'(load_bank);
         row_d  = RW'(load_row);
         col_d  = '0;
      end else if (advance) begin
         if (last_col) begin
            col_d = '0;
            if (row_q == RW'(BUFH - 1)) begin
               row_d  = '0;
               bank_d = (bank_q == BW'(POY - 1)) ? '0 : bank_q + BW'(1);
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         bank_q <= bank_d;
         row_q  <= row_d;
         col_q  <= col_d;
      end
   end

   assign bank = bank_q;
   assign row  = row_q;
   assign col  = col_q;

endmodule

// File: rtl/ibuf_burst_writer.sv
// Converts a DRAM burst stream into indexed buffer writes (bank/row/col), one row per burst.
// Writes appear one cycle after the accepted beat; done coincides with the final write.
module ibuf_burst_writer
   import ibuf_pkg::*;
#(
   parameter int DW     = 32,
   parameter int POY    = 3,
   parameter int STRIDE = 1,
   parameter int BUFW   = 32,
   parameter int CNTW   = 16
) (
   input logic                clk,
   input logic                rst_n,
   ibuf_burst_writer_if.slave bus
);
   localparam int BUFH = bufh_of(STRIDE);
   localparam int BW   = idx_w(POY);
   localparam int RW   = ral(BUFH);
   localparam int CW   = idx_w(BUFW);

   state_t state_q, state_d;

   logic            cmd_fire;
   logic            beat;
   logic            last_col;
   logic [BW-1:0]   bank;
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;

   logic [CNTW-1:0]    remcnt_q, remcnt_d;
   logic               wvalid_q, wvalid_d;
   logic [DW-1:0]      wdata_q, wdata_d;
   logic [WBANK_W-1:0] wbank_q, wbank_d;
   logic [WROW_W-1:0]  wrow_q, wrow_d;
   logic [WCOL_W-1:0]  wcol_q, wcol_d;
   logic               row_done_q, row_done_d;
   logic               done_q, done_d;
   logic               err_last_q, err_last_d;

   ibuf_addr_gen #(
      .POY  (POY),
      .BUFH (BUFH),
      .BUFW (BUFW)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (cmd_fire),
      .load_bank (bus.cmd_bank),
      .load_row  (bus.cmd_row),
      .advance   (beat),
      .bank      (bank),
      .row       (row),
      .col       (col),
      .last_col  (last_col)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_fire) state_d = (bus.cmd_nburst == '0) ? FIN : LOAD;
         LOAD:    if (beat && last_col && (remcnt_q == CNTW'(1))) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state_q == IDLE);
      bus.s_ready   = (state_q == LOAD);
      bus.dbg_state = state_q;
      cmd_fire      = bus.cmd_valid && (state_q == IDLE);
      beat          = bus.s_valid && (state_q == LOAD);
   end

   // Address fields capture the counters before they advance on this beat.
   always_comb begin
      remcnt_d   = remcnt_q;
      wvalid_d   = beat;
      wdata_d    = wdata_q;
      wbank_d    = wbank_q;
      wrow_d     = wrow_q;
      wcol_d     = wcol_q;
      row_done_d = beat && last_col;
      done_d     = (state_d == FIN);
      err_last_d = err_last_q;
      if (cmd_fire) begin
         remcnt_d = bus.cmd_nburst;
      end else if (beat && last_col) begin
         remcnt_d = remcnt_q - CNTW'(1);
      end
      if (beat) begin
         wdata_d = bus.s_data;
         wbank_d = WBANK_W'(bank);
         wrow_d  = WROW_W'(row);
         wcol_d  = WCOL_W'(col);
         if (bus.s_last != last_col) err_last_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         remcnt_q   <= '0;
         wvalid_q   <= 1'b0;
         wdata_q    <= '0;
         wbank_q    <= '0;
         wrow_q     <= '0;
         wcol_q     <= '0;
         row_done_q <= 1'b0;
         done_q     <= 1'b0;
         err_last_q <= 1'b0;
      end else begin
         remcnt_q   <= remcnt_d;
         wvalid_q   <= wvalid_d;
         wdata_q    <= wdata_d;
         wbank_q    <= wbank_d;
         wrow_q     <= wrow_d;
         wcol_q     <= wcol_d;
         row_done_q <= row_done_d;
         done_q     <= done_d;
         err_last_q <= err_last_d;
      end
   end

   assign bus.wvalid   = wvalid_q;
   assign bus.wdata    = wdata_q;
   assign bus.wbank    = wbank_q;
   assign bus.wrow     = wrow_q;
   assign bus.wcol     = wcol_q;
   assign bus.row_done = row_done_q;
   assign bus.done     = done_q;
   assign bus.err_last = err_last_q;

endmodule

// File: doc/ibuf_burst_writer.md
Name: ibuf_burst_writer

Overview:
- Upstream stage of the input-buffer data router; converts a DRAM burst stream into indexed writes on the buffer's write port (wvalid/wdata/wbank/wrow/wcol).
- A command specifies a starting bank/row and a number of row-bursts. Each burst is BUFW words long and fills one buffer row, columns 0..BUFW-1.
- Rows then advance through BUFH = 2*STRIDE rows per bank, and banks advance through POY banks, with wrap-around.

Parameters:
- DW, 32, data word width
- POY, 3, number of buffer banks (output rows in parallel)
- STRIDE, 1, convolution stride; BUFH = 2*STRIDE is a localparam
- BUFW, 32, words per burst and per buffer row
- CNTW, 16, width of burst-count field

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_bank  in  8  starting bank, 0..POY-1
- cmd_row  in  8  starting row, 0..BUFH-1
- cmd_nburst  in  CNTW  number of bursts; 0 is legal
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat accepted when s_valid && s_ready
- s_data  in  DW  stream data
- s_last  in  1  last beat of burst, from source
- wvalid  out  1  buffer write strobe
- wdata  out  DW  buffer write data
- wbank  out  8  buffer bank index
- wrow  out  8  buffer row index
- wcol  out  28  buffer column index
- row_done  out  1  one-cycle pulse with the write of column BUFW-1
- done  out  1  one-cycle pulse when the command completes
- err_last  out  1  sticky s_last framing error

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values:
  - state=IDLE
  - cmd_ready=1, s_ready=0
  - wvalid=0, wdata=0, wbank=0, wrow=0, wcol=0
  - row_done=0, done=0, err_last=0
- FSM states: IDLE, LOAD, FIN.
- IDLE:
  - cmd_ready=1.
  - On command handshake, latch bank/row and remcnt=cmd_nburst, and set col=0.
  - If cmd_nburst==0, go to FIN; otherwise go to LOAD.
- LOAD:
  - s_ready=1 and cmd_ready=0. Commands are ignored until the FSM returns to IDLE.
- Accepted beat:
  - On the next cycle, register wvalid=1, wdata=s_data and wbank/wrow/wcol = current bank/row/col (write latency 1 cycle).
  - wvalid=0 in every cycle after a cycle with no accepted beat.
- Counter advance on each accepted beat:
  - col increments.
  - When col==BUFW-1: col->0, row_done=1 (aligned with that write), and remcnt decrements.
  - On that same beat, row increments; if row==BUFH-1, row->0 and bank increments; if bank==POY-1, bank->0.
  - If remcnt was 1, go to FIN.
- Framing check:
  - err_last is set if s_last != (col==BUFW-1) on an accepted beat.
  - err_last clears only on reset. Addressing continues from the counters and ignores s_last.
- FIN:
  - done=1 for exactly one cycle; s_ready=0; then return to IDLE.
  - On the FIN cycle, the last write (wvalid=1) is already on the outputs, so done coincides with the last write.
  - For nburst=0, done is asserted one cycle after the command.
- Backpressure: the writer never stalls the buffer. Gaps in s_valid simply produce wvalid=0 cycles and leave counters unchanged.
- Out-of-range cmd_bank/cmd_row: behaviour is undefined; the verification bench never drives them.
- Reset mid-LOAD: all state and outputs return to reset values on the next edge. Partially written rows are abandoned.
- Widths: col is clog2(BUFW) bits and is zero-extended to 28 on wcol. Bank and row are zero-extended to 8.

Decomposition:
- Package ibuf_pkg holds:
  - the state enum (IDLE/LOAD/FIN)
  - the BUFH = 2*STRIDE and RAL/LM localparam functions shared with the data router
  - the write-port width constants (8/8/28)
- One sub-module is natural: ibuf_addr_gen, the wrap-around col/row/bank counter with advance and load inputs and a last_col flag.
- The FSM, output registers and framing check stay in the top.

Test Plan:
- Defaults, cmd bank=0 row=0 nburst=1, 32 continuous beats data=i:
  - writes (0,0,0..31) with wdata=0..31.
  - row_done and done both fire with the write of col 31.
  - cmd_ready returns to 1 the next cycle.
- cmd bank=2 row=1 nburst=3:
  - burst 0 goes to (2,1), burst 1 to (0,0), burst 2 to (0,1), confirming row and bank wrap.
- s_valid toggled 1-0-1 every other cycle for one burst:
  - 32 writes with a wvalid=0 gap between each.
  - Columns stay contiguous 0..31; done fires once.
- cmd nburst=0:
  - s_ready stays 0, no writes occur.
  - done pulses 1 cycle after the command handshake.
- s_last asserted at col 15 of a burst:
  - err_last=1 from the next cycle and stays set.
  - Addressing continues to col 31 unchanged.
- rst_n=0 for 1 cycle at beat 10 of a 2-burst command:
  - next cycle all outputs are at reset values, state is IDLE, cmd_ready=1.
  - A new command restarts at col 0.
